// File: rtl/function_return_stack.sv
// function_return_stack: call/return address stack with a registered TOS; FRS_HIGH_WATER_EN adds HIGH_WATER.
module function_return_stack #(
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] PC_IN,
  input  logic                  CTRL_PUSH,
  input  logic                  CTRL_POP,
  input  logic                  SEL_RET_OFFSET,
  output logic [ADDR_WIDTH-1:0] RET_ADDR_OUT,
  output logic                  FULL,
  output logic                  EMPTY,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW,
  output logic [CNT_WIDTH-1:0]  COUNT_OUT
`ifdef FRS_HIGH_WATER_EN
  ,
  output logic [CNT_WIDTH-1:0]  HIGH_WATER
`endif
);
  localparam int IW = $clog2(DEPTH);
  logic [ADDR_WIDTH-1:0] arr_q [DEPTH-1];
  logic [ADDR_WIDTH-1:0] arr_d [DEPTH-1];
  logic [ADDR_WIDTH-1:0] tos_q, tos_d, ra;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cm1, cm2;
  logic ovf_q, ovf_d, unf_q, unf_d, empty, full, repl, push, pop;
  always_comb begin
    ra = PC_IN + {{(ADDR_WIDTH-2){1'b0}}, SEL_RET_OFFSET, ~SEL_RET_OFFSET};
    empty = cnt_q == '0;
    full = cnt_q == CNT_WIDTH'(DEPTH);
    repl = CTRL_PUSH & CTRL_POP & ~empty;
    push = CTRL_PUSH & ~repl & ~full;
    pop = CTRL_POP & ~CTRL_PUSH & ~empty;
    ovf_d = ovf_q | (CTRL_PUSH & ~CTRL_POP & full);
    unf_d = unf_q | (CTRL_POP & ~CTRL_PUSH & empty);
    cm1 = cnt_q - CNT_WIDTH'(1);
    cm2 = cnt_q - CNT_WIDTH'(2);
    arr_d = arr_q;
    if (push && !empty) arr_d[cm1[IW-1:0]] = tos_q;
    tos_d = (push || repl) ? ra : (pop && cnt_q > CNT_WIDTH'(1)) ? arr_q[cm2[IW-1:0]] : tos_q;
    cnt_d = push ? cnt_q + CNT_WIDTH'(1) : pop ? cm1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      tos_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      tos_q <= tos_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_ff @(posedge clk) arr_q <= arr_d;
`ifdef FRS_HIGH_WATER_EN
  logic [CNT_WIDTH-1:0] hw_q, hw_d;
  always_comb hw_d = (cnt_d > hw_q) ? cnt_d : hw_q;
  always_ff @(posedge clk) hw_q <= reset ? '0 : hw_d;
  assign HIGH_WATER = hw_q;
`endif
  assign RET_ADDR_OUT = tos_q;
  assign COUNT_OUT = cnt_q;
  assign EMPTY = empty;
  assign FULL = full;
  assign OVERFLOW = ovf_q;
  assign UNDERFLOW = unf_q;
endmodule

// File: tb/tb_function_return_stack.sv
// tb_function_return_stack: random + directed stimulus against a queue-based return-stack model.
module tb_function_return_stack;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [11:0] PC_IN = '0;
  logic CTRL_PUSH = 1'b0, CTRL_POP = 1'b0, SEL_RET_OFFSET = 1'b0;
  logic [11:0] RET_ADDR_OUT;
  logic FULL, EMPTY, OVERFLOW, UNDERFLOW;
  logic [4:0] COUNT_OUT;
`ifdef FRS_HIGH_WATER_EN
  logic [4:0] HIGH_WATER;
`endif
  int errors = 0, checks = 0;
  bit chk_en = 1'b0;
  int m_stk[$];
  int m_ret = 0, m_hw = 0;
  bit m_ovf = 1'b0, m_unf = 1'b0;
  function_return_stack dut (
    .clk(clk), .reset(reset), .PC_IN(PC_IN), .CTRL_PUSH(CTRL_PUSH), .CTRL_POP(CTRL_POP),
    .SEL_RET_OFFSET(SEL_RET_OFFSET), .RET_ADDR_OUT(RET_ADDR_OUT), .FULL(FULL), .EMPTY(EMPTY),
    .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW), .COUNT_OUT(COUNT_OUT)
`ifdef FRS_HIGH_WATER_EN
    , .HIGH_WATER(HIGH_WATER)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  // Reference: the whole stack lives in a queue, top at the back.
  always @(posedge clk) begin
    int ra;
    ra = (int'(PC_IN) + (SEL_RET_OFFSET ? 2 : 1)) % 4096;
    if (reset) begin
      m_stk.delete();
      m_ret = 0; m_ovf = 0; m_unf = 0; m_hw = 0;
    end else if (CTRL_PUSH && CTRL_POP && m_stk.size() > 0) begin
      m_stk[m_stk.size()-1] = ra;
      m_ret = ra;
    end else if (CTRL_PUSH) begin
      if (m_stk.size() == 16) m_ovf = 1;
      else begin
        m_stk.push_back(ra);
        m_ret = ra;
      end
    end else if (CTRL_POP) begin
      if (m_stk.size() == 0) m_unf = 1;
      else begin
        void'(m_stk.pop_back());
        if (m_stk.size() > 0) m_ret = m_stk[m_stk.size()-1];
      end
    end
    if (m_stk.size() > m_hw) m_hw = m_stk.size();
  end
  always @(negedge clk) if (chk_en) begin
    chk("ret", int'(RET_ADDR_OUT), m_ret);
    chk("count", int'(COUNT_OUT), m_stk.size());
    chk("full", int'(FULL), int'(m_stk.size() == 16));
    chk("empty", int'(EMPTY), int'(m_stk.size() == 0));
    chk("ovf", int'(OVERFLOW), int'(m_ovf));
    chk("unf", int'(UNDERFLOW), int'(m_unf));
`ifdef FRS_HIGH_WATER_EN
    chk("hw", int'(HIGH_WATER), m_hw);
`endif
  end
  task automatic step(bit p, bit o, int pc, bit sel, bit r = 0);
    CTRL_PUSH = p; CTRL_POP = o; PC_IN = 12'(pc); SEL_RET_OFFSET = sel; reset = r;
    @(negedge clk);
    CTRL_PUSH = 0; CTRL_POP = 0; reset = 0;
  endtask
  initial begin
    step(0, 0, 0, 0, 1);
    chk_en = 1;
    repeat (3) step(0, 0, 0, 0);
    chk("rst_ret", int'(RET_ADDR_OUT), 0);
    chk("rst_empty", int'(EMPTY), 1);
    chk("rst_full", int'(FULL), 0);
    chk("rst_cnt", int'(COUNT_OUT), 0);
    chk("rst_flags", int'({OVERFLOW, UNDERFLOW}), 0);
    step(1, 0, 'h010, 0);
    step(1, 0, 'h020, 1);
    chk("push2_ret", int'(RET_ADDR_OUT), 'h022);
    chk("push2_cnt", int'(COUNT_OUT), 2);
    chk("popcyc_ret", int'(RET_ADDR_OUT), 'h022);
    step(0, 1, 0, 0);
    chk("pop1_ret", int'(RET_ADDR_OUT), 'h011);
    chk("pop1_cnt", int'(COUNT_OUT), 1);
    step(0, 1, 0, 0);
    chk("pop2_empty", int'(EMPTY), 1);
    for (int n = 0; n < 16; n++) step(1, 0, n, 0);
    chk("fill_full", int'(FULL), 1);
    step(1, 0, 'h030, 0);
    chk("ovf_set", int'(OVERFLOW), 1);
    chk("ovf_ret", int'(RET_ADDR_OUT), 'h010);
    for (int i = 0; i < 16; i++) begin
      chk("drain_ret", int'(RET_ADDR_OUT), 16 - i);
      step(0, 1, 0, 0);
    end
    chk("drain_empty", int'(EMPTY), 1);
    step(0, 1, 0, 0);
    chk("unf_set", int'(UNDERFLOW), 1);
    chk("unf_cnt", int'(COUNT_OUT), 0);
    chk("unf_ret", int'(RET_ADDR_OUT), 'h001);
    step(1, 0, 'h100, 0);
    chk("after_unf_ret", int'(RET_ADDR_OUT), 'h101);
    chk("unf_sticky", int'(UNDERFLOW), 1);
    step(0, 0, 0, 0, 1);
    step(1, 0, 'hFFF, 1);
    chk("wrap_ret", int'(RET_ADDR_OUT), 'h001);
    step(1, 1, 'h050, 0);
    chk("tail_ret", int'(RET_ADDR_OUT), 'h051);
    chk("tail_cnt", int'(COUNT_OUT), 1);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 'h200 + i, 0);
`ifdef FRS_HIGH_WATER_EN
    chk("hw_pre", int'(HIGH_WATER), 3);
`endif
    step(1, 0, 'h300, 0, 1);
    chk("rst_push_cnt", int'(COUNT_OUT), 0);
    chk("rst_push_ret", int'(RET_ADDR_OUT), 0);
    chk("rst_push_flags", int'({OVERFLOW, UNDERFLOW}), 0);
`ifdef FRS_HIGH_WATER_EN
    chk("hw_post", int'(HIGH_WATER), 0);
`endif
    // Alternate push-heavy and pop-heavy phases so both boundaries get hit.
    for (int ph = 0; ph < 8; ph++)
      for (int i = 0; i < 300; i++) begin
        int r;
        r = $urandom_range(99);
        step((ph % 2 == 0) ? (r < 60) : (r < 25), $urandom_range(99) < ((ph % 2 == 0) ? 25 : 60),
             $urandom, 1'($urandom), $urandom_range(299) == 0);
      end
    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
